// File: rtl/nor_nbx_filt.sv
// nor_nbx_filt
// Qualifies a bundle of raw (possibly asynchronous) status inputs into one clean
// decode flag. Each input is optionally inverted, synchronised into the clock
// domain, reduced with NOR (or OR), and then passed through a consecutive-sample
// stability filter before reaching the registered output O. CHG pulses for one
// cycle whenever O toggles.
module nor_nbx_filt #(
    parameter int                 WIDTH       = 5,
    parameter logic [WIDTH-1:0]   INV_MASK    = WIDTH'(5'b00111),
    parameter bit                 MODE        = 1'b0,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 FILTER      = 4
) (
    input  logic             C,
    input  logic             CLRN,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    output logic             O,
    output logic             O_RAW,
    output logic             CHG
);

    // Counter only has to reach FILTER-1, so clog2(FILTER) bits suffice; keep
    // at least one bit so the FILTER=1 case still has a legal vector.
    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    // Output value the reduction produces when every synchronised input is 0.
    // Reset lands O here so that a quiet bus after reset causes no toggle.
    localparam logic F0 = MODE ? (|INV_MASK) : ~(|INV_MASK);

    // The filter has two states; the state is not stored separately but is
    // implied by whether the reduced value disagrees with the current output.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity check (simulation only).
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    generate
        if ((WIDTH < 2) || (WIDTH > 32) || (FILTER < 1) || (FILTER > 255) ||
            (SYNC_STAGES < 0) || (SYNC_STAGES > 3)) begin : g_bad_params
            // Stop the simulation immediately on an unsupported configuration.
            initial begin
                $display("nor_nbx_filt: illegal parameters WIDTH=%0d FILTER=%0d SYNC_STAGES=%0d",
                         WIDTH, FILTER, SYNC_STAGES);
                $finish;
            end
        end
    endgenerate
`endif

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            // Inputs are already synchronous: feed them straight to the reduction.
            assign w_s = I;
        end else begin : g_sync
            logic [WIDTH-1:0] r_sync [SYNC_STAGES];

            // Shift register that runs every clock, independent of CE, so the
            // synchronised view of I is always current when CE returns.
            always_ff @(posedge C or negedge CLRN) begin
                if (!CLRN) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= '0;
                    end
                end else begin
                    r_sync[0] <= I;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-bit inversion and reduction
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_x;
    logic             w_raw;

    // Apply the inversion mask bit by bit before the reduction.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
            assign w_x[gi] = w_s[gi] ^ INV_MASK[gi];
        end
    endgenerate

    assign w_raw = MODE ? (|w_x) : ~(|w_x);
    assign O_RAW = w_raw;

    // ------------------------------------------------------------------
    // Stability filter
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;
    logic          r_o;
    logic          r_chg;

    state_t        w_state;
    logic [CW-1:0] w_cnt_next;
    logic          w_o_next;
    logic          w_chg_next;

    assign w_state = (w_raw == r_o) ? ST_IDLE : ST_PENDING;

    // Filter state register: O, the agreement counter and the change pulse.
    always_ff @(posedge C or negedge CLRN) begin
        if (!CLRN) begin
            r_cnt <= '0;
            r_o   <= F0;
            r_chg <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_o   <= w_o_next;
            r_chg <= w_chg_next;
        end
    end

    // Next-state logic: count consecutive disagreeing samples, toggle O once
    // FILTER of them have been seen, and drop the count on any agreeing sample.
    always_comb begin
        w_cnt_next = r_cnt;
        w_o_next   = r_o;
        w_chg_next = 1'b0;
        if (CE) begin
            unique case (w_state)
                ST_IDLE: begin
                    // Reduced value matches O: any partial count was a glitch.
                    w_cnt_next = '0;
                end
                ST_PENDING: begin
                    if (r_cnt == CNT_LAST) begin
                        w_o_next   = ~r_o;
                        w_cnt_next = '0;
                        w_chg_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    assign O   = r_o;
    assign CHG = r_chg;

endmodule

// File: tb/tb_nor_nbx_filt.sv
// tb_nor_nbx_filt
// Directed bench: one instance with default parameters (NOR, mask 00111,
// 2 sync stages, filter 4) and one in OR mode with no sync and filter 1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_nor_nbx_filt;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       rst_n;
    logic       ce;
    logic [4:0] din;
    logic       o, o_raw, chg;

    // OR-mode, unsynchronised, unfiltered instance
    logic       rst6_n;
    logic       ce6;
    logic [4:0] din6;
    logic       o6, o_raw6, chg6;

    int n_total = 0;
    int n_bad   = 0;

    nor_nbx_filt u_dut (
        .C     (clk),
        .CLRN  (rst_n),
        .CE    (ce),
        .I     (din),
        .O     (o),
        .O_RAW (o_raw),
        .CHG   (chg)
    );

    nor_nbx_filt #(
        .WIDTH       (5),
        .INV_MASK    (5'b00000),
        .MODE        (1'b1),
        .SYNC_STAGES (0),
        .FILTER      (1)
    ) u_dut6 (
        .C     (clk),
        .CLRN  (rst6_n),
        .CE    (ce6),
        .I     (din6),
        .O     (o6),
        .O_RAW (o_raw6),
        .CHG   (chg6)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end else begin
            $display("ok   %s = %b", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rst6_n = 1'b0;
        ce     = 1'b1;
        ce6    = 1'b1;
        din    = 5'b00000;
        din6   = 5'b00000;

        // ---- 1: reset state and quiet release ----
        repeat (3) step();
        chk("t1_rst_o",     o,      1'b0);
        chk("t1_rst_chg",   chg,    1'b0);
        chk("t1_rst_oraw",  o_raw,  1'b0);
        chk("t6_rst_o",     o6,     1'b0);
        chk("t6_rst_chg",   chg6,   1'b0);
        rst_n  = 1'b1;
        rst6_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("t1_hold_o[%0d]", k),   o,   1'b0);
            chk($sformatf("t1_hold_chg[%0d]", k), chg, 1'b0);
        end

        // ---- 2: stable change, O rises 6 cycles later with one CHG ----
        din = 5'b00111;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("t2_oraw[%0d]", k), o_raw, (k >= 2));
            chk($sformatf("t2_o[%0d]", k),    o,     (k >= 6));
            chk($sformatf("t2_chg[%0d]", k),  chg,   (k == 6));
        end

        // ---- 3: 3-cycle glitch with O=1 is rejected ----
        din = 5'b01111;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) din = 5'b00111;
            chk($sformatf("t3_oraw[%0d]", k), o_raw, !(k >= 2 && k <= 4));
            chk($sformatf("t3_o[%0d]", k),    o,     1'b1);
            chk($sformatf("t3_chg[%0d]", k),  chg,   1'b0);
        end

        // ---- 4: CE low mid-count freezes the filter ----
        din = 5'b00000;
        repeat (8) step();
        chk("t4_pre_o", o, 1'b0);
        din = 5'b00111;
        repeat (4) step();          // counter has reached 2
        ce = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("t4_hold_o[%0d]", k),   o,   1'b0);
            chk($sformatf("t4_hold_chg[%0d]", k), chg, 1'b0);
        end
        ce = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("t4_o[%0d]", k),   o,   (k >= 2));
            chk($sformatf("t4_chg[%0d]", k), chg, (k == 2));
        end

        // ---- 5: reset mid-count discards the count and returns O to 0 ----
        din = 5'b00000;
        repeat (4) step();          // counter has reached 2, O still 1
        chk("t5_pre_o", o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_o",   o,   1'b0);
        chk("t5_async_chg", chg, 1'b0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("t5_o[%0d]", k),   o,   1'b0);
            chk($sformatf("t5_chg[%0d]", k), chg, 1'b0);
        end

        // ---- 6: OR mode, no sync, filter 1 ----
        din6 = 5'b00100;
        #1;
        chk("t6_oraw_hi", o_raw6, 1'b1);
        step();
        chk("t6_rise_o",   o6,   1'b1);
        chk("t6_rise_chg", chg6, 1'b1);
        din6 = 5'b00110;            // raw stays 1: no activity
        step();
        chk("t6_same_o",   o6,   1'b1);
        chk("t6_same_chg", chg6, 1'b0);
        din6 = 5'b00000;
        step();
        chk("t6_fall_o",   o6,   1'b0);
        chk("t6_fall_chg", chg6, 1'b1);
        step();
        chk("t6_idle_o",   o6,   1'b0);
        chk("t6_idle_chg", chg6, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
